bram_result_reader: RTL and testbench
=====================================

Name: bram_result_reader

Overview:
Drains the result BRAM (BRAM1) after an accumulate run and streams each 64-bit row out on a valid/ready interface. Each row packs four 16-bit core results. This is the read-side counterpart of the accumulate-and-write engine. It drives the BRAM1 memory interface in read-only mode and hands rows to a host DMA or AXI-Stream bridge, with a 1-cycle BRAM read latency and full backpressure support.

Parameters:
CNT_BIT, 31, width of run_count_i
DWIDTH, 64, BRAM1 row width and stream data width
AWIDTH, 8, BRAM1 address width
MEM_SIZE, 256, BRAM1 depth in rows
FIFO_DEPTH, 2, output buffer depth in rows; must be at least 2 for 1 beat/cycle

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start_i  input  1  start pulse; sampled only in IDLE
run_count_i  input  CNT_BIT  number of rows to read
idle_o  output  1  state is IDLE
run_o  output  1  state is RUN
done_o  output  1  state is DONE (one cycle)
addr_b1_o  output  AWIDTH  BRAM1 address
ce_b1_o  output  1  BRAM1 chip enable
we_b1_o  output  1  BRAM1 write enable; tied to 0
d_b1_o  output  DWIDTH  BRAM1 write data; tied to 0
q_b1_i  input  DWIDTH  BRAM1 read data; valid 1 cycle after ce_b1_o
m_valid_o  output  1  stream data valid
m_ready_i  input  1  stream sink ready
m_data_o  output  DWIDTH  row data, as {result_4, result_3, result_2, result_1}
m_last_o  output  1  marks the final row of the run

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset values:
  - idle_o=1; all other state outputs 0.
  - ce_b1_o=0, addr_b1_o=0, m_valid_o=0, m_data_o=0, m_last_o=0.
  - FIFO empty, all counters 0.
- Tie-offs: we_b1_o=0 and d_b1_o=0 at all times.
- FSM, one-hot or binary, 3 states:
  - IDLE -> RUN on start_i=1. Latch N = min(run_count_i, MEM_SIZE), clear counters.
  - If N=0, IDLE -> DONE directly; no ce_b1_o is issued and no beats are produced.
  - RUN -> DONE on the handshake edge of beat N (m_valid_o & m_ready_i with m_last_o=1).
  - DONE -> IDLE unconditionally after 1 cycle.
  - start_i in RUN or DONE is ignored.
- Issue counter (AWIDTH+1 bits), in RUN:
  - Assert ce_b1_o with addr_b1_o = issue_cnt when issue_cnt < N AND fifo_cnt + inflight - pop < FIFO_DEPTH.
  - pop = m_valid_o & m_ready_i in the same cycle.
  - This combinational ready-to-ce path is intended.
  - ce_b1_o=0 whenever no read is issued; addr_b1_o holds its last value.
- In-flight flag: set in the cycle after a ce_b1_o assertion. In that cycle q_b1_i is written into the FIFO. No row is ever dropped or duplicated.
- FIFO: FIFO_DEPTH entries, first-word fall-through registered output.
  - m_valid_o = not empty.
  - m_data_o is held stable while m_valid_o & !m_ready_i.
- Beat counter: increments on each pop. m_last_o = m_valid_o & (beat_cnt == N-1).
- Latency, with start sampled at edge E0:
  - RUN from E0; first ce_b1_o in the cycle after E0.
  - q_b1_i is captured at E2; m_valid_o goes high after E2.
- Throughput: with m_ready_i held high, 1 row per cycle back-to-back. The final handshake at edge Ek is followed by done_o=1 for exactly the cycle after Ek.
- Backpressure: while m_ready_i=0, at most FIFO_DEPTH rows are outstanding (FIFO plus in-flight); issue stalls.
- Addresses run 0..N-1; there is no wrap. N=MEM_SIZE reads rows 0..MEM_SIZE-1 exactly.
- Reset mid-run: immediate return to reset values. Any in-flight BRAM data is discarded.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE;
  - RESULT_WIDTH=16 and LANES=4, with DWIDTH = LANES*RESULT_WIDTH;
  - the lane slicing convention (lane k at bits [16k+15:16k]).
- One natural sub-module, result_stream_fifo: parameterized depth/width FIFO with push, pop, count, empty and full outputs.
- FSM and counters stay in the top module.

Test Plan:
- Rows 0..3 preloaded with 0x0004_0003_0002_0001 + i; run_count_i=4, m_ready_i=1:
  - beats rows 0..3 on 4 consecutive cycles, first beat 2 cycles after RUN entry;
  - m_last_o only on row 3;
  - done_o one cycle later, then idle_o=1.
- run_count_i=8, m_ready_i toggling 1,0,0,1,…:
  - all 8 rows out in order, none duplicated;
  - m_data_o stable while stalled;
  - never more than 2 reads outstanding.
- run_count_i=0: done_o=1 the cycle after start; ce_b1_o never asserted; m_valid_o stays 0.
- run_count_i=300: exactly 256 beats, addresses 0..255; m_last_o on row 255.
- reset_n low after 3 beats of an 8-row run: all outputs at reset values; a new start with run_count_i=2 yields rows 0 and 1.
- start_i pulsed during RUN of a 5-row run: ignored; exactly 5 beats and a single done_o.

Source files
------------

// File: rtl/bram_result_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_result_reader_pkg
//  Purpose  : Shared definitions for the BRAM1 result reader. Holds the FSM
//             state encoding, the row layout (four 16-bit lanes per row) and
//             a helper that extracts one lane from a row.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bram_result_reader_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Row layout: lane k occupies bits [16k+15:16k], so a row reads as
  // {result_4, result_3, result_2, result_1} from MSB to LSB.
  localparam int RESULT_WIDTH = 16;
  localparam int LANES        = 4;
  localparam int ROW_WIDTH    = LANES * RESULT_WIDTH;

  function automatic logic [RESULT_WIDTH-1:0] lane_of(
    input logic [ROW_WIDTH-1:0] row,
    input int                   k
  );
    return row[k*RESULT_WIDTH +: RESULT_WIDTH];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_result_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_stream_fifo
//  Purpose  : Small first-word-fall-through FIFO buffering rows between the
//             BRAM read port and the output stream. The head entry is
//             presented on pop_data straight from the storage registers.
//  Ports    : clk, reset_n        - clock, asynchronous active-low reset
//             push, push_data     - write one entry
//             pop                 - consume the head entry
//             pop_data            - head entry (valid while !empty)
//             count, empty, full  - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module result_stream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_result_reader
//  Purpose  : Drains N rows of the result BRAM (BRAM1) and streams them out
//             on a valid/ready interface, with full backpressure support and
//             one row per cycle when the sink is always ready.
//  Ports    : clk, reset_n                - clock, async active-low reset
//             start_i, run_count_i        - run request and row count
//             idle_o, run_o, done_o       - FSM state indicators
//             addr_b1_o, ce_b1_o, we_b1_o,
//             d_b1_o, q_b1_i              - BRAM1 port (read-only use)
//             m_valid_o, m_ready_i,
//             m_data_o, m_last_o          - output row stream
//  Revision : 1.0 - initial release
// ============================================================================
module bram_result_reader
  import bram_result_reader_pkg::*;
#(
  parameter int CNT_BIT    = 31,
  parameter int DWIDTH     = 64,
  parameter int AWIDTH     = 8,
  parameter int MEM_SIZE   = 256,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [CNT_BIT-1:0] run_count_i,
  output logic               idle_o,
  output logic               run_o,
  output logic               done_o,
  output logic [AWIDTH-1:0]  addr_b1_o,
  output logic               ce_b1_o,
  output logic               we_b1_o,
  output logic [DWIDTH-1:0]  d_b1_o,
  input  logic [DWIDTH-1:0]  q_b1_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [DWIDTH-1:0]  m_data_o,
  output logic               m_last_o
);

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = FIFO_CNT_W + 1;
  localparam int CW         = AWIDTH + 1;
  localparam logic [CNT_BIT-1:0] MEM_SIZE_CNT = CNT_BIT'(MEM_SIZE);

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       n_rows;
  logic [CW-1:0]       n_start;
  logic [CW-1:0]       issue_cnt;
  logic [CW-1:0]       beat_cnt;
  logic                inflight;
  logic [AWIDTH-1:0]   addr_q;
  logic                start_acc;
  logic                pop;
  logic                issue;
  logic [OCC_W-1:0]    occ;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic                fifo_empty;
  logic                fifo_full;

  // Row count clamped to the BRAM depth; addresses never wrap.
  assign n_start   = (run_count_i > MEM_SIZE_CNT) ? CW'(MEM_SIZE) : run_count_i[CW-1:0];
  assign start_acc = (state == S_IDLE) & start_i;
  assign pop       = m_valid_o & m_ready_i;

  // Rows already committed to the FIFO once this cycle settles: buffered
  // rows plus the one arriving from BRAM, minus the one leaving now. Using
  // the same-cycle pop lets the reader sustain one row per cycle with only
  // two buffer slots, at the cost of a combinational ready-to-ce path.
  assign occ   = OCC_W'(fifo_cnt) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue = (state == S_RUN) && (issue_cnt < n_rows) &&
                 (occ < OCC_W'(FIFO_DEPTH)) && !(fifo_full && !pop);

  assign ce_b1_o   = issue;
  assign addr_b1_o = issue ? issue_cnt[AWIDTH-1:0] : addr_q;
  assign we_b1_o   = 1'b0;
  assign d_b1_o    = '0;

  assign m_valid_o = ~fifo_empty;
  assign m_last_o  = m_valid_o & (beat_cnt == n_rows - CW'(1));

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idle_o    = 1'b0;
    run_o     = 1'b0;
    done_o    = 1'b0;
    case (state)
      S_IDLE: begin
        idle_o = 1'b1;
        if (start_i) begin
          state_nxt = (n_start == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        run_o = 1'b1;
        if (pop && m_last_o) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- counters ---
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_rows    <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
      addr_q    <= '0;
    end else begin
      // BRAM data for a read issued this cycle is present next cycle.
      inflight <= issue;
      if (issue) begin
        addr_q <= issue_cnt[AWIDTH-1:0];
      end
      if (start_acc) begin
        n_rows    <= n_start;
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + CW'(1);
        end
        if (pop) begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  // ------------------------------------------------------- output FIFO ---
  result_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (q_b1_i),
    .pop       (pop),
    .pop_data  (m_data_o),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_bram_result_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_result_reader
//  Purpose  : Self-checking bench for bram_result_reader. Expected rows are
//             queued when a run is started; a monitor compares every stream
//             handshake against the queue and watches the BRAM port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_result_reader;

  localparam int CNT_BIT    = 31;
  localparam int DWIDTH     = 64;
  localparam int AWIDTH     = 8;
  localparam int MEM_SIZE   = 256;
  localparam int FIFO_DEPTH = 2;

  logic               clk;
  logic               reset_n;
  logic               start_i;
  logic [CNT_BIT-1:0] run_count_i;
  logic               idle_o;
  logic               run_o;
  logic               done_o;
  logic [AWIDTH-1:0]  addr_b1_o;
  logic               ce_b1_o;
  logic               we_b1_o;
  logic [DWIDTH-1:0]  d_b1_o;
  logic [DWIDTH-1:0]  q_b1_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [DWIDTH-1:0]  m_data_o;
  logic               m_last_o;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mem [MEM_SIZE];
  int          checks   = 0;
  int          failures = 0;
  int          issued   = 0;
  int          beats    = 0;
  int          exp_addr = 0;
  int          done_cnt = 0;
  logic        prev_stall   = 1'b0;
  logic        prev_last_hs = 1'b0;
  logic [63:0] prev_data    = '0;

  bram_result_reader #(
    .CNT_BIT    (CNT_BIT),
    .DWIDTH     (DWIDTH),
    .AWIDTH     (AWIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .run_count_i (run_count_i),
    .idle_o      (idle_o),
    .run_o       (run_o),
    .done_o      (done_o),
    .addr_b1_o   (addr_b1_o),
    .ce_b1_o     (ce_b1_o),
    .we_b1_o     (we_b1_o),
    .d_b1_o      (d_b1_o),
    .q_b1_i      (q_b1_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM1 model: one-cycle read latency
  initial q_b1_i = '0;
  always @(posedge clk) begin
    if (ce_b1_o) q_b1_i <= mem[addr_b1_o];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_tb();
    sb_q.delete();
    issued       = 0;
    beats        = 0;
    exp_addr     = 0;
    prev_stall   = 1'b0;
    prev_last_hs = 1'b0;
  endtask

  // Queue the expected rows, then pulse start for one cycle.
  task automatic do_start(input int n);
    int   k;
    exp_t e;
    k = (n > MEM_SIZE) ? MEM_SIZE : n;
    for (int i = 0; i < k; i++) begin
      e.data = mem[i];
      e.last = (i == k - 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start_i     = 1'b1;
    run_count_i = n[CNT_BIT-1:0];
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  // Wait for the next done_o, optionally toggling ready as 1,0,0,1,...
  task automatic run_until_done(input bit toggle, input int budget);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      m_ready_i = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
    end
    m_ready_i = 1'b1;
    check("done_reached", 64'(seen), 64'd1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_last_hs) check("done_after_last", 64'(done_o), 64'd1);
      if (prev_stall) begin
        check("stall_valid_held", 64'(m_valid_o), 64'd1);
        check("stall_data_held", m_data_o, prev_data);
      end
      if (m_valid_o && m_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_data_o);
        end else begin
          e = sb_q.pop_front();
          check("beat_data", m_data_o, e.data);
          check("beat_last", 64'(m_last_o), 64'(e.last));
        end
        beats++;
      end
      if (ce_b1_o) begin
        check("read_addr", 64'(addr_b1_o), 64'(exp_addr[7:0]));
        exp_addr++;
        issued++;
        check("outstanding_le_2", 64'((issued - beats) <= FIFO_DEPTH), 64'd1);
      end
      if (done_o) done_cnt++;
      prev_stall   = m_valid_o & ~m_ready_i;
      prev_data    = m_data_o;
      prev_last_hs = m_valid_o & m_ready_i & m_last_o;
    end
  end

  initial begin : stim
    int d0;
    int budget;
    reset_n     = 1'b0;
    start_i     = 1'b0;
    run_count_i = '0;
    m_ready_i   = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 64'h0004_0003_0002_0001 + 64'(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_run", 64'(run_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ce", 64'(ce_b1_o), 64'd0);
    check("rst_addr", 64'(addr_b1_o), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_data", m_data_o, 64'd0);
    check("rst_last", 64'(m_last_o), 64'd0);
    check("rst_we", 64'(we_b1_o), 64'd0);
    check("rst_d", d_b1_o, 64'd0);
    #1 reset_n = 1'b1;
    reset_tb();

    // 4 rows, sink always ready: timing and back-to-back beats
    do_start(4);
    @(negedge clk);
    check("t1_run_entry", 64'(run_o), 64'd1);
    check("t1_first_ce", 64'(ce_b1_o), 64'd1);
    check("t1_first_addr", 64'(addr_b1_o), 64'd0);
    check("t1_no_valid_e0", 64'(m_valid_o), 64'd0);
    @(negedge clk);
    check("t1_no_valid_e1", 64'(m_valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_valid_b2b", 64'(m_valid_o), 64'd1);
      check("t1_last_pos", 64'(m_last_o), 64'(i == 3));
    end
    @(negedge clk);
    check("t1_done", 64'(done_o), 64'd1);
    @(negedge clk);
    check("t1_idle_after", 64'(idle_o), 64'd1);
    check("t1_beats", 64'(beats), 64'd4);
    check("t1_queue_empty", 64'(sb_q.size()), 64'd0);

    // 8 rows with backpressure pattern 1,0,0,1
    reset_tb();
    do_start(8);
    run_until_done(1'b1, 400);
    check("t2_beats", 64'(beats), 64'd8);
    check("t2_issued", 64'(issued), 64'd8);
    check("t2_queue_empty", 64'(sb_q.size()), 64'd0);

    // Zero-length run
    reset_tb();
    do_start(0);
    @(negedge clk);
    check("t3_done_next", 64'(done_o), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("t3_no_valid", 64'(m_valid_o), 64'd0);
    end
    check("t3_no_ce", 64'(issued), 64'd0);
    check("t3_no_beats", 64'(beats), 64'd0);

    // Oversized request clamps to the BRAM depth
    reset_tb();
    do_start(300);
    run_until_done(1'b0, 600);
    check("t4_beats", 64'(beats), 64'd256);
    check("t4_addrs", 64'(exp_addr), 64'd256);
    check("t4_queue_empty", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of an 8-row run
    reset_tb();
    do_start(8);
    budget = 0;
    while (beats < 3 && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    check("t5_reached_3_beats", 64'(beats >= 3), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_idle", 64'(idle_o), 64'd1);
    check("t5_rst_run", 64'(run_o), 64'd0);
    check("t5_rst_ce", 64'(ce_b1_o), 64'd0);
    check("t5_rst_addr", 64'(addr_b1_o), 64'd0);
    check("t5_rst_valid", 64'(m_valid_o), 64'd0);
    check("t5_rst_data", m_data_o, 64'd0);
    check("t5_rst_last", 64'(m_last_o), 64'd0);
    reset_tb();
    @(negedge clk); #1;
    reset_n = 1'b1;
    do_start(2);
    run_until_done(1'b0, 50);
    check("t5_beats", 64'(beats), 64'd2);
    check("t5_queue_empty", 64'(sb_q.size()), 64'd0);

    // start pulsed during RUN is ignored
    reset_tb();
    d0 = done_cnt;
    do_start(5);
    @(posedge clk); #1;
    start_i     = 1'b1;
    run_count_i = 31'd3;
    @(posedge clk); #1;
    start_i     = 1'b0;
    run_until_done(1'b0, 50);
    repeat (10) @(negedge clk);
    #1;
    check("t6_single_done", 64'(done_cnt - d0), 64'd1);
    check("t6_beats", 64'(beats), 64'd5);
    check("t6_queue_empty", 64'(sb_q.size()), 64'd0);
    check("t6_idle", 64'(idle_o), 64'd1);
    check("tie_we", 64'(we_b1_o), 64'd0);
    check("tie_d", d_b1_o, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
